// File: rtl/cpu_checker_pkg.sv
// Shared definitions for the streaming trace-line checker.
//
// Holds the FSM state encoding, the ASCII characters the parser keys on,
// the format_type codes reported for a completed line and the bit
// positions of the semantic error flags on error_code.
package cpu_checker_pkg;

  // One state per syntactic field of a trace line, plus the two
  // one-cycle report states.
  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_TIME  = 4'd1,
    S_PC    = 4'd2,
    S_SP0   = 4'd3,
    S_GRF   = 4'd4,
    S_ADDR  = 4'd5,
    S_LT    = 4'd6,
    S_EQ    = 4'd7,
    S_SPD   = 4'd8,
    S_DATA  = 4'd9,
    S_DONE1 = 4'd10,
    S_DONE2 = 4'd11
  } state_e;

  // Characters that delimit the fields of a line.
  localparam logic [7:0] CH_CARET  = 8'h5E; // '^'
  localparam logic [7:0] CH_AT     = 8'h40; // '@'
  localparam logic [7:0] CH_COLON  = 8'h3A; // ':'
  localparam logic [7:0] CH_DOLLAR = 8'h24; // '$'
  localparam logic [7:0] CH_STAR   = 8'h2A; // '*'
  localparam logic [7:0] CH_LT     = 8'h3C; // '<'
  localparam logic [7:0] CH_EQ     = 8'h3D; // '='
  localparam logic [7:0] CH_HASH   = 8'h23; // '#'
  localparam logic [7:0] CH_SPACE  = 8'h20; // ' '

  // Line type reported on format_type.
  localparam logic [1:0] FMT_NONE = 2'd0;
  localparam logic [1:0] FMT_REG  = 2'd1;
  localparam logic [1:0] FMT_MEM  = 2'd2;

  // Bit positions inside error_code.
  localparam int ERR_TIME_ODD = 0;
  localparam int ERR_PC       = 1;
  localparam int ERR_ADDR     = 2;
  localparam int ERR_GRF      = 3;

  // Width of the shared per-field digit counter; every digit-count
  // parameter must stay below 2**CNT_W.
  localparam int CNT_W = 8;

endpackage

// File: rtl/cpu_checker_ext_ascii_class.sv
// Combinational character classifier.
//
// Ports:
//   char_i     - ASCII character under inspection
//   is_dec_o   - character is '0'..'9'
//   is_hex_o   - character is '0'..'9' or 'a'..'f' (lowercase only)
//   dec_val_o  - decimal value of the digit (0 when not a decimal digit)
//   hex_val_o  - hex value of the digit (0 when not a hex digit)
module ascii_class (
  input  logic [7:0] char_i,
  output logic       is_dec_o,
  output logic       is_hex_o,
  output logic [3:0] dec_val_o,
  output logic [3:0] hex_val_o
);

  logic isLowerHex;

  // The low nibble of '0'..'9' is the digit value; 'a'..'f' have low
  // nibbles 1..6, so adding 9 yields 10..15.
  always_comb begin
    is_dec_o   = (char_i >= 8'h30) && (char_i <= 8'h39);
    isLowerHex = (char_i >= 8'h61) && (char_i <= 8'h66);
    is_hex_o   = is_dec_o || isLowerHex;
    dec_val_o  = 4'd0;
    hex_val_o  = 4'd0;
    if (is_dec_o) begin
      dec_val_o = char_i[3:0];
      hex_val_o = char_i[3:0];
    end else if (isLowerHex) begin
      hex_val_o = char_i[3:0] + 4'd9;
    end
  end

endmodule

// File: rtl/cpu_checker_ext.sv
// Streaming checker for simulator trace lines, one ASCII character per clock.
//
// Recognises register-write lines  ^<time>@<pc>: $<grf> <= <data>#
// and memory-write lines           ^<time>@<pc>: *<addr> <= <data>#
// and raises semantic error flags for the fields of a completed line.
//
// Ports:
//   clk         - clock, rising edge
//   reset       - synchronous, active-low
//   char        - ASCII character, sampled every rising edge
//   format_type - 0 none, 1 register-write line, 2 memory-write line
//                 (one cycle, the cycle after '#' is sampled)
//   error_code  - error flags for the reported line, 0 when format_type==0
module cpu_checker_ext
  import cpu_checker_pkg::*;
#(
  parameter int unsigned  TIME_DIGITS_MAX = 4,
  parameter int unsigned  GRF_DIGITS_MAX  = 4,
  parameter int unsigned  HEX_DIGITS      = 8,
  parameter logic [31:0]  PC_LO           = 32'h0000_3000,
  parameter logic [31:0]  PC_HI           = 32'h0000_4fff,
  parameter logic [31:0]  ADDR_HI         = 32'h0000_2fff,
  parameter int unsigned  GRF_MAX         = 31
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] char,
  output logic [1:0] format_type,
  output logic [3:0] error_code
);

  // Just wide enough for the largest legal grf value, 10**digits - 1.
  localparam int GRF_W = $clog2(10 ** GRF_DIGITS_MAX);

  localparam logic [CNT_W-1:0] TIME_MAX_C = CNT_W'(TIME_DIGITS_MAX);
  localparam logic [CNT_W-1:0] GRF_MAX_C  = CNT_W'(GRF_DIGITS_MAX);
  localparam logic [CNT_W-1:0] HEX_C      = CNT_W'(HEX_DIGITS);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               timeOdd_q, timeOdd_d;
  logic               isMem_q, isMem_d;
  logic [31:0]        pc_q, pc_d;
  logic [31:0]        addr_q, addr_d;
  logic [GRF_W-1:0]   grf_q, grf_d;

  logic               isDec;
  logic               isHex;
  logic [3:0]         decVal;
  logic [3:0]         hexVal;
  logic               bad;

  ascii_class u_class (
    .char_i    (char),
    .is_dec_o  (isDec),
    .is_hex_o  (isHex),
    .dec_val_o (decVal),
    .hex_val_o (hexVal)
  );

  // State and accumulator registers; reset throws away any partial line.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      timeOdd_q <= 1'b0;
      isMem_q   <= 1'b0;
      pc_q      <= '0;
      addr_q    <= '0;
      grf_q     <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      timeOdd_q <= timeOdd_d;
      isMem_q   <= isMem_d;
      pc_q      <= pc_d;
      addr_q    <= addr_d;
      grf_q     <= grf_d;
    end
  end

  // Next-state logic. cnt_q counts digits of the field being parsed and is
  // cleared whenever the parser moves to a new field. Any character that
  // does not fit the current state raises 'bad'; a bad '^' restarts a line
  // with clean accumulators, anything else drops back to IDLE. The IDLE and
  // DONE states treat every character as bad, which gives exactly that.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    timeOdd_d = timeOdd_q;
    isMem_d   = isMem_q;
    pc_d      = pc_q;
    addr_d    = addr_q;
    grf_d     = grf_q;
    bad       = 1'b0;

    unique case (state_q)
      S_TIME: begin
        if (isDec && (cnt_q < TIME_MAX_C)) begin
          cnt_d     = cnt_q + 1'b1;
          timeOdd_d = decVal[0];
        end else if ((char == CH_AT) && (cnt_q != '0)) begin
          state_d = S_PC;
          cnt_d   = '0;
        end else begin
          bad = 1'b1;
        end
      end

      S_PC: begin
        if (isHex && (cnt_q < HEX_C)) begin
          cnt_d = cnt_q + 1'b1;
          pc_d  = {pc_q[27:0], hexVal};
        end else if ((char == CH_COLON) && (cnt_q == HEX_C)) begin
          state_d = S_SP0;
          cnt_d   = '0;
        end else begin
          bad = 1'b1;
        end
      end

      S_SP0: begin
        if (char == CH_SPACE) begin
          state_d = S_SP0;
        end else if (char == CH_DOLLAR) begin
          state_d = S_GRF;
          isMem_d = 1'b0;
        end else if (char == CH_STAR) begin
          state_d = S_ADDR;
          isMem_d = 1'b1;
        end else begin
          bad = 1'b1;
        end
      end

      // A '<' straight after the digits is the zero-space case of the
      // trailing spaces, so it skips the LT state.
      S_GRF: begin
        if (isDec && (cnt_q < GRF_MAX_C)) begin
          cnt_d = cnt_q + 1'b1;
          grf_d = grf_q * GRF_W'(10) + GRF_W'(decVal);
        end else if ((char == CH_SPACE) && (cnt_q != '0)) begin
          state_d = S_LT;
        end else if ((char == CH_LT) && (cnt_q != '0)) begin
          state_d = S_EQ;
        end else begin
          bad = 1'b1;
        end
      end

      S_ADDR: begin
        if (isHex && (cnt_q < HEX_C)) begin
          cnt_d  = cnt_q + 1'b1;
          addr_d = {addr_q[27:0], hexVal};
        end else if ((char == CH_SPACE) && (cnt_q == HEX_C)) begin
          state_d = S_LT;
        end else if ((char == CH_LT) && (cnt_q == HEX_C)) begin
          state_d = S_EQ;
        end else begin
          bad = 1'b1;
        end
      end

      S_LT: begin
        if (char == CH_SPACE) begin
          state_d = S_LT;
        end else if (char == CH_LT) begin
          state_d = S_EQ;
        end else begin
          bad = 1'b1;
        end
      end

      S_EQ: begin
        if (char == CH_EQ) begin
          state_d = S_SPD;
        end else begin
          bad = 1'b1;
        end
      end

      // The first data digit is consumed here, so DATA starts counting at 1.
      S_SPD: begin
        if (char == CH_SPACE) begin
          state_d = S_SPD;
        end else if (isHex) begin
          state_d = S_DATA;
          cnt_d   = CNT_W'(1);
        end else begin
          bad = 1'b1;
        end
      end

      S_DATA: begin
        if (isHex && (cnt_q < HEX_C)) begin
          cnt_d = cnt_q + 1'b1;
        end else if ((char == CH_HASH) && (cnt_q == HEX_C)) begin
          state_d = isMem_q ? S_DONE2 : S_DONE1;
          cnt_d   = '0;
        end else begin
          bad = 1'b1;
        end
      end

      default: begin
        bad = 1'b1;
      end
    endcase

    if (bad) begin
      state_d   = (char == CH_CARET) ? S_TIME : S_IDLE;
      cnt_d     = '0;
      timeOdd_d = 1'b0;
      isMem_d   = 1'b0;
      pc_d      = '0;
      addr_d    = '0;
      grf_d     = '0;
    end
  end

  // Moore outputs: the report and its flags exist only in the DONE states,
  // where the accumulators still hold the fields of the finished line.
  always_comb begin
    format_type = FMT_NONE;
    error_code  = 4'd0;
    if ((state_q == S_DONE1) || (state_q == S_DONE2)) begin
      format_type              = (state_q == S_DONE1) ? FMT_REG : FMT_MEM;
      error_code[ERR_TIME_ODD] = timeOdd_q;
      error_code[ERR_PC]       = (pc_q[1:0] != 2'b00) || (pc_q < PC_LO) ||
                                 (pc_q > PC_HI);
      if (state_q == S_DONE2) begin
        error_code[ERR_ADDR] = (addr_q[1:0] != 2'b00) || (addr_q > ADDR_HI);
      end else begin
        error_code[ERR_GRF]  = 32'(grf_q) > GRF_MAX;
      end
    end
  end

endmodule

// File: tb/tb_cpu_checker_ext.sv
// Directed testbench for cpu_checker_ext: feeds trace lines one character
// per clock and compares format_type/error_code against hand-computed values.
module tb_cpu_checker_ext;

  logic       clk;
  logic       reset;
  logic [7:0] char;
  logic [1:0] format_type;
  logic [3:0] error_code;

  int checks;
  int errors;
  int early;

  cpu_checker_ext dut (
    .clk         (clk),
    .reset       (reset),
    .char        (char),
    .format_type (format_type),
    .error_code  (error_code)
  );

  // Free-running clock, 10 time units per cycle.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts one comparison and reports it when observed and expected differ.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Drives a string one character per clock and samples 1 unit after each
  // edge. Counts any report seen before the final character was sampled.
  task automatic applyStimulus(input string s, output int nz);
    nz = 0;
    for (int i = 0; i < s.len(); i++) begin
      char = s[i];
      @(posedge clk);
      #1;
      if ((i != s.len() - 1) && (format_type != 2'd0)) nz++;
    end
  endtask

  // One idle character (a space) so a report state is left.
  task automatic idleCycle();
    char = 8'h20;
    @(posedge clk);
    #1;
  endtask

  // Sends a line and checks the report right after '#' and the cycle after.
  task automatic checkLine(input string tag, input string s,
                           input logic [1:0] fmt, input logic [3:0] err);
    applyStimulus(s, early);
    checkOutput({tag, "_early"}, early, 0);
    checkOutput({tag, "_fmt"}, format_type, fmt);
    checkOutput({tag, "_err"}, error_code, err);
    idleCycle();
    checkOutput({tag, "_fmt_after"}, format_type, 2'd0);
    checkOutput({tag, "_err_after"}, error_code, 4'd0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b0;
    char   = 8'h20;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_fmt", format_type, 2'd0);
    checkOutput("reset_err", error_code, 4'd0);
    reset = 1'b1;
    idleCycle();

    checkLine("reg_basic", "^24@00003010: $1 <= 0000000a#", 2'd1, 4'b0000);
    checkLine("mem_odd", "^7@00003010: *00000004<=00000001#", 2'd2, 4'b0001);
    checkLine("reg_bad", "^10@00002002:   $40   <=  00000000#", 2'd1, 4'b1010);
    checkLine("upper_hex", "^2@00003000: *00003001 <= 0000000F#", 2'd0, 4'b0000);
    checkLine("mem_addr", "^2@00003000: *00003001 <= 0000000f#", 2'd2, 4'b0100);
    checkLine("time5", "^12345@00003000: $1 <= 00000000#", 2'd0, 4'b0000);
    checkLine("restart", "^1@000^4@00003000: $0 <= 00000000#", 2'd1, 4'b0000);
    checkLine("bounds_hi", "^9999@00004ffc: $31 <= ffffffff#", 2'd1, 4'b0001);
    checkLine("pc_over", "^0000@00005000: *00002ffc <= 12345678#", 2'd2, 4'b0010);
    checkLine("grf32", "^8@00003004: $0032 <= abcdef01#", 2'd1, 4'b1000);
    checkLine("no_time", "^@00003000: $1 <= 00000000#", 2'd0, 4'b0000);
    checkLine("short_pc", "^2@0003000: $1 <= 00000000#", 2'd0, 4'b0000);

    // Reset in the middle of a line discards the partial line.
    applyStimulus("^4@0000", early);
    reset = 1'b0;
    char  = 8'h30;
    repeat (2) begin
      @(posedge clk);
      #1;
      checkOutput("midreset_fmt", format_type, 2'd0);
      checkOutput("midreset_err", error_code, 4'd0);
    end
    reset = 1'b1;
    checkLine("discarded", "0000: $1 <= 00000000#", 2'd0, 4'b0000);
    checkLine("after_reset", "^6@00003008: $2 <= 00000001#", 2'd1, 4'b0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
